// File: rtl/approx_norm_multiplier.sv
// Sequential approximate 16x16 unsigned multiplier: both operands are left-normalized,
// then their top 8 bits are multiplied by an 8-cycle shift-add engine.
module approx_norm_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Y,
  output logic        done
);

  localparam int unsigned OP_W   = 16;
  localparam int unsigned MAN_W  = 8;
  localparam int unsigned RES_W  = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STEP_W = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_NORM = 3'd2,
    S_MULT = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [OP_W-1:0]   ra_q, ra_d;
  logic [OP_W-1:0]   rb_q, rb_d;
  logic              zero_q, zero_d;
  logic [CNT_W-1:0]  norm_cnt_q, norm_cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [RES_W-1:0]  mcand_q, mcand_d;
  logic [MAN_W-1:0]  mplier_q, mplier_d;
  logic [RES_W-1:0]  acc_q, acc_d;
  logic [RES_W-1:0]  y_q, y_d;
  logic              done_q, done_d;

  logic [OP_W-1:0]   ra_sh_c;
  logic [OP_W-1:0]   rb_sh_c;
  logic              norm_done_c;

  // One normalization step per operand; an operand already normalized holds.
  always_comb begin
    ra_sh_c     = ra_q[OP_W-1] ? ra_q : {ra_q[OP_W-2:0], 1'b0};
    rb_sh_c     = rb_q[OP_W-1] ? rb_q : {rb_q[OP_W-2:0], 1'b0};
    norm_done_c = (ra_sh_c[OP_W-1] & rb_sh_c[OP_W-1]) ||
                  (norm_cnt_q == CNT_W'(OP_W - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        if (zero_q) begin
          state_d = S_DONE;
        end else if (ra_q[OP_W-1] & rb_q[OP_W-1]) begin
          state_d = S_MULT;
        end else begin
          state_d = S_NORM;
        end
      end
      S_NORM: if (norm_done_c) state_d = S_MULT;
      S_MULT: if (step_q == STEP_W'(MAN_W - 1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: mantissa registers are primed on every step that may lead into MULT.
  always_comb begin
    ra_d       = ra_q;
    rb_d       = rb_q;
    zero_d     = zero_q;
    norm_cnt_d = norm_cnt_q;
    step_d     = step_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    y_d        = y_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ra_d   = A;
          rb_d   = B;
          zero_d = (A == '0) || (B == '0);
        end
      end
      S_LOAD: begin
        norm_cnt_d = '0;
        step_d     = '0;
        acc_d      = '0;
        mcand_d    = {(RES_W-MAN_W)'(0), ra_q[OP_W-1 -: MAN_W]};
        mplier_d   = rb_q[OP_W-1 -: MAN_W];
      end
      S_NORM: begin
        ra_d       = ra_sh_c;
        rb_d       = rb_sh_c;
        norm_cnt_d = norm_cnt_q + CNT_W'(1);
        mcand_d    = {(RES_W-MAN_W)'(0), ra_sh_c[OP_W-1 -: MAN_W]};
        mplier_d   = rb_sh_c[OP_W-1 -: MAN_W];
      end
      S_MULT: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = {mcand_q[RES_W-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[MAN_W-1:1]};
        step_d   = step_q + STEP_W'(1);
      end
      S_DONE: begin
        y_d    = zero_q ? '0 : acc_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ra_q       <= '0;
      rb_q       <= '0;
      zero_q     <= 1'b0;
      norm_cnt_q <= '0;
      step_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      y_q        <= '0;
      done_q     <= 1'b0;
    end else begin
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      zero_q     <= zero_d;
      norm_cnt_q <= norm_cnt_d;
      step_q     <= step_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      y_q        <= y_d;
      done_q     <= done_d;
    end
  end

  assign Y    = y_q;
  assign done = done_q;

endmodule

// File: tb/tb_approx_norm_multiplier.sv
// Scoreboard bench for approx_norm_multiplier: directed operands with hand-computed
// mantissa products and start-to-done latencies.
module tb_approx_norm_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] Y;
  logic        done;

  always #5 clk = ~clk;

  approx_norm_multiplier dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Y     (Y),
    .done  (done)
  );

  typedef struct {
    logic [15:0] y;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    string       name;
    logic [15:0] y;
    logic        d;
  } probe_t;

  exp_t   sb[$];
  probe_t pq[$];
  int     cyc    = 0;
  int     checks = 0;
  int     passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: owns all counting; resolves probes, done pulses and overdue operations.
  always @(negedge clk) begin
    exp_t   e;
    probe_t p;
    while (pq.size() > 0) begin
      p = pq.pop_front();
      checks++;
      if (Y === p.y && done === p.d) passes++;
      else $display("FAIL %s: Y=%h done=%b, required Y=%h done=%b", p.name, Y, done, p.y, p.d);
    end
    if (done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_done: Y=%h with no operation pending", Y);
      end else begin
        e = sb.pop_front();
        if (Y === e.y && (cyc - e.acc) == e.lat) passes++;
        else $display("FAIL result: Y=%h latency=%0d, required Y=%h latency=%0d",
                      Y, cyc - e.acc, e.y, e.lat);
      end
    end else if (sb.size() > 0 && cyc > sb[0].acc + sb[0].lat + 8) begin
      e = sb.pop_front();
      checks++;
      $display("FAIL timeout: no done by cycle %0d, required Y=%h latency=%0d", cyc, e.y, e.lat);
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] y, input int lat);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    e.y = y;
    e.acc = cyc + 1;
    e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic probe(input string n, input logic [15:0] y, input logic d);
    probe_t p;
    @(posedge clk);
    #1;
    p.name = n;
    p.y = y;
    p.d = d;
    pq.push_back(p);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   c;
    rst   = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    probe("reset_state", 16'h0000, 1'b0);
    A = 16'h1000;
    B = 16'h2E00;
    start = 1'b1;
    probe("start_in_reset_a", 16'h0000, 1'b0);
    probe("start_in_reset_b", 16'h0000, 1'b0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;

    issue(16'h1000, 16'h2E00, 16'h5C00, 13); drain();
    probe("y_hold", 16'h5C00, 1'b0);
    issue(16'h0002, 16'h05C0, 16'h5C00, 24); drain();
    issue(16'hFFFF, 16'h8000, 16'h7F80, 10); drain();
    issue(16'h0000, 16'h1234, 16'h0000, 2);  drain();
    issue(16'hABCD, 16'h0000, 16'h0000, 2);  drain();
    issue(16'h0001, 16'h0001, 16'h4000, 25); drain();
    issue(16'h00FF, 16'h0003, 16'hBF40, 24); drain();
    issue(16'h1234, 16'h5678, 16'h616C, 13);
    A = 16'hFFFF;
    B = 16'hFFFF;
    drain();

    // Start pulse during MULT must be dropped.
    issue(16'hFFFF, 16'h8000, 16'h7F80, 10);
    repeat (3) @(negedge clk);
    A = 16'h0001;
    B = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (30) @(negedge clk);
    probe("busy_start_ignored", 16'h7F80, 1'b0);

    // Start held through DONE relaunches on the first IDLE edge.
    @(negedge clk);
    A = 16'h0000;
    B = 16'h1234;
    start = 1'b1;
    c = cyc + 1;
    e.y = 16'h0000; e.acc = c;     e.lat = 2; sb.push_back(e);
    e.y = 16'h0000; e.acc = c + 3; e.lat = 2; sb.push_back(e);
    repeat (4) @(negedge clk);
    start = 1'b0;
    drain();

    // Reset in the middle of NORM aborts without a done pulse.
    issue(16'h1000, 16'h2E00, 16'h5C00, 13); drain();
    @(negedge clk);
    A = 16'h0001;
    B = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    probe("reset_abort", 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    probe("after_abort", 16'h0000, 1'b0);
    issue(16'hFFFF, 16'h8000, 16'h7F80, 10); drain();

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
